mem_responder: RTL

- Memory-side responder for the core's instruction-fetch and load/store traffic: the slave end of the core's memory request interface.
- Two independent valid/ready ports, inst (read-only) and data (read/write with byte mask), over one word-organised storage array.
- Each port has a fixed, configurable response latency.
- Sits below the core in the simulation top and serves as the synthesizable memory model for bring-up.

---
 rtl/mem_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: synchronous memory model with an instruction-fetch port and a
// load/store port sharing one word-organised array. Each port runs its own
// IDLE -> WAIT -> RESP handshake FSM with a fixed response latency; the ports
// never stall each other.
module mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1c000000,
  parameter int                    DEPTH_LOG2 = 14,
  parameter int                    LATENCY    = 1   // 1..15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  input  logic [ADDR_WIDTH-1:0] inst_req_addr,
  output logic                  inst_resp_valid,
  input  logic                  inst_resp_ready,
  output logic [DATA_WIDTH-1:0] inst_resp_data,
  output logic                  inst_resp_err,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic [ADDR_WIDTH-1:0] data_req_addr,
  input  logic                  data_req_we,
  input  logic [3:0]            data_req_wmask,
  input  logic [DATA_WIDTH-1:0] data_req_wdata,
  output logic                  data_resp_valid,
  input  logic                  data_resp_ready,
  output logic [DATA_WIDTH-1:0] data_resp_rdata,
  output logic                  data_resp_err
);

  localparam int NP    = 2;              // port 0 = inst, port 1 = data
  localparam int IDX_W = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  // Misaligned, below the base, or beyond the last word.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> (DEPTH_LOG2 + 2)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Storage array; not reset, written only by accepted, in-range stores.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NP-1:0]         p_req_valid, p_req_ready, p_req_we, p_accept, p_acc_err;
  logic [NP-1:0]         p_resp_valid, p_resp_ready, p_resp_err;
  logic [ADDR_WIDTH-1:0] p_req_addr  [NP];
  logic [DATA_WIDTH-1:0] p_resp_data [NP];

  assign p_req_valid   = {data_req_valid, inst_req_valid};
  assign p_req_we      = {data_req_we, 1'b0};
  assign p_resp_ready  = {data_resp_ready, inst_resp_ready};
  assign p_req_addr[0] = inst_req_addr;
  assign p_req_addr[1] = data_req_addr;

  assign inst_req_ready  = p_req_ready[0];
  assign inst_resp_valid = p_resp_valid[0];
  assign inst_resp_data  = p_resp_data[0];
  assign inst_resp_err   = p_resp_err[0];
  assign data_req_ready  = p_req_ready[1];
  assign data_resp_valid = p_resp_valid[1];
  assign data_resp_rdata = p_resp_data[1];
  assign data_resp_err   = p_resp_err[1];

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;          // error flag of the pending request
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  cap, cap_err, cap_we;
    logic [IDX_W-1:0]      rd_idx;

    assign p_req_ready[p]  = (state_q == S_IDLE) && !reset;
    assign p_accept[p]     = p_req_valid[p] && p_req_ready[p];
    assign p_acc_err[p]    = addr_err(p_req_addr[p]);
    assign p_resp_valid[p] = (state_q == S_RESP);
    assign p_resp_data[p]  = resp_data_q;
    assign p_resp_err[p]   = resp_err_q;

    // Next-state logic; the read word is captured on the edge that enters RESP.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      cap         = 1'b0;
      cap_err     = err_q;
      cap_we      = we_q;
      rd_idx      = word_idx(addr_q);
      case (state_q)
        S_IDLE: begin
          if (p_accept[p]) begin
            addr_d = p_req_addr[p];
            we_d   = p_req_we[p];
            err_d  = p_acc_err[p];
            cnt_d  = LAT_M1;
            if (LATENCY == 1) begin
              // Single-cycle latency: capture straight from the request fields.
              state_d = S_RESP;
              cap     = 1'b1;
              cap_err = p_acc_err[p];
              cap_we  = p_req_we[p];
              rd_idx  = word_idx(p_req_addr[p]);
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
            cap     = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (p_resp_ready[p]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (cap) begin
        resp_err_d  = cap_err;
        resp_data_d = (cap_err || cap_we) ? '0 : mem[rd_idx];
      end
    end

    // Control and response registers; reset drops any pending transaction.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q     <= S_IDLE;
        cnt_q       <= 4'd0;
        resp_data_q <= '0;
        resp_err_q  <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        resp_data_q <= resp_data_d;
        resp_err_q  <= resp_err_d;
      end
    end

    // Request fields latched at acceptance; meaningless outside a transaction.
    always_ff @(posedge clock) begin
      addr_q <= addr_d;
      we_q   <= we_d;
      err_q  <= err_d;
    end
  end

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  assign wr_en  = p_accept[1] && data_req_we && !p_acc_err[1];
  assign wr_idx = word_idx(data_req_addr);

  // Stores commit at the acceptance edge; a same-edge read capture sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_req_wmask[b]) mem[wr_idx][8*b +: 8] <= data_req_wdata[8*b +: 8];
      end
    end
  end

endmodule
